// File: rtl/mar_pkg.sv
// Shared encodings for the mar_burst address register and its step unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   op_e     - manual operation codes on the op port
//   state_e  - burst sequencer states
//   DIR_*    - step direction codes shared by manual and burst paths
package mar_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_LOAD = 2'b01,
        OP_INC  = 2'b10,
        OP_DEC  = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Direction codes match the burst_dir port encoding, so a latched
    // burst_dir can drive the step unit directly.
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/mar_step.sv
// Wrapping +/-1 address step against a programmable upper limit.
// Latency: combinational, zero cycles.
// Backpressure: none; result is valid whenever inputs are.
//
// Ports:
//   addr - current address
//   lim  - highest valid address; increment past it (or from above it) wraps to 0
//   dir  - DIR_UP / DIR_DN
//   next - stepped address
//   wrap - high when this step wrapped
module mar_step
    import mar_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic [AW-1:0] addr,
    input  logic [AW-1:0] lim,
    input  logic          dir,
    output logic [AW-1:0] next,
    output logic          wrap
);

    localparam logic [AW-1:0] ONE = AW'(1);

    always_comb begin
        next = '0;
        wrap = 1'b0;
        if (dir == DIR_DN) begin
            if (addr == '0) begin
                next = lim;
                wrap = 1'b1;
            end else begin
                next = addr - ONE;
            end
        end else begin
            // >= rather than == so that a loaded value above lim still
            // lands back in range on its first increment.
            if (addr >= lim) begin
                next = '0;
                wrap = 1'b1;
            end else begin
                next = addr + ONE;
            end
        end
    end

endmodule

// File: rtl/mar_burst.sv
// Memory address register with gated load/inc/dec and a burst sequencer.
// Latency: manual ops and burst steps update mar_out one cycle after the edge; done/wrapped are 1-cycle pulses.
// Backpressure: none; a gated request is always accepted in IDLE, and a running burst ignores everything but a gated load (abort).
//
// Ports:
//   clk, rst_n        - clock; synchronous active-low reset
//   d_in              - load value (stored unclamped)
//   op                - 00 hold, 01 load, 10 inc, 11 dec
//   g, g1, g2         - all three high form the gate
//   burst_start       - gated burst request
//   burst_len         - number of burst steps (0 gives an immediate done)
//   burst_dir         - 0 increment, 1 decrement
//   lim               - wrap limit, highest valid address
//   mar_out           - current address
//   busy              - burst in progress
//   done              - pulse after the final burst step (or a zero-length burst)
//   wrapped           - pulse after any step that wrapped
module mar_burst
    import mar_pkg::*;
#(
    parameter int AW = 4,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] d_in,
    input  logic [1:0]    op,
    input  logic          g,
    input  logic          g1,
    input  logic          g2,
    input  logic          burst_start,
    input  logic [LW-1:0] burst_len,
    input  logic          burst_dir,
    input  logic [AW-1:0] lim,
    output logic [AW-1:0] mar_out,
    output logic          busy,
    output logic          done,
    output logic          wrapped
);

    localparam logic [LW-1:0] CNT_ONE = LW'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e        r_state;
    logic [AW-1:0] r_mar;
    logic [LW-1:0] r_cnt;
    logic          r_dir;
    logic          r_done;
    logic          r_wrap;

    state_e        w_state_nxt;
    logic [AW-1:0] w_mar_nxt;
    logic [LW-1:0] w_cnt_nxt;
    logic          w_dir_nxt;
    logic          w_done_nxt;
    logic          w_wrap_nxt;

    logic          w_gate;
    logic          w_step_dir;
    logic [AW-1:0] w_step_next;
    logic          w_step_wrap;

    assign w_gate = g & g1 & g2;

    // One step unit serves both paths: while a burst runs the latched
    // direction owns it, otherwise the manual op selects the direction.
    assign w_step_dir = (r_state == ST_RUN)   ? r_dir  :
                        (op == OP_DEC)        ? DIR_DN : DIR_UP;

    mar_step #(
        .AW (AW)
    ) u_step (
        .addr (r_mar),
        .lim  (lim),
        .dir  (w_step_dir),
        .next (w_step_next),
        .wrap (w_step_wrap)
    );

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_mar_nxt   = r_mar;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_done_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_gate) begin
                    if (burst_start) begin
                        // A burst request takes priority over op.
                        if (burst_len != '0) begin
                            w_dir_nxt   = burst_dir;
                            w_cnt_nxt   = burst_len;
                            w_state_nxt = ST_RUN;
                        end else begin
                            // Zero-length burst completes immediately.
                            w_done_nxt = 1'b1;
                        end
                    end else begin
                        case (op_e'(op))
                            OP_LOAD: w_mar_nxt = d_in;
                            OP_INC, OP_DEC: begin
                                w_mar_nxt  = w_step_next;
                                w_wrap_nxt = w_step_wrap;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            ST_RUN: begin
                if (w_gate && (op == OP_LOAD)) begin
                    // Abort: the load wins and the burst ends silently.
                    w_mar_nxt   = d_in;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_mar_nxt  = w_step_next;
                    w_wrap_nxt = w_step_wrap;
                    w_cnt_nxt  = r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mar   <= '0;
            r_cnt   <= '0;
            r_dir   <= DIR_UP;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mar   <= w_mar_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_done  <= w_done_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign mar_out = r_mar;
    assign busy    = (r_state == ST_RUN);
    assign done    = r_done;
    assign wrapped = r_wrap;

endmodule
